// File: rtl/breadboard_sweeper.sv
// Steps the breadboard through all 16 input rows, captures f_in after a settle interval,
// streams each captured row over valid/ready and folds it into a rotate-XOR signature.
module breadboard_sweeper #(
  parameter int unsigned SETTLE = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [9:0] i_f_in,
  input  logic       i_row_ready,
  output logic       o_w,
  output logic       o_x,
  output logic       o_y,
  output logic       o_z,
  output logic       o_row_valid,
  output logic [3:0] o_row_index,
  output logic [9:0] o_row_data,
  output logic       o_busy,
  output logic       o_done,
  output logic [9:0] o_sig
);

  localparam logic [7:0] SettleLast = 8'(SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StPresent, StDone} state_e;

  state_e     r_state;
  logic [3:0] r_row;
  logic [7:0] r_cnt;
  logic       r_valid;
  logic [3:0] r_index;
  logic [9:0] r_data;
  logic       r_busy;
  logic       r_done;
  logic [9:0] r_sig;

  logic w_xfer;
  logic w_last;
  logic w_settled;

  assign w_xfer    = r_valid & i_row_ready;
  assign w_last    = (r_row == 4'hF);
  assign w_settled = (r_cnt == SettleLast);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_row   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_index <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sig   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_row   <= '0;
            r_cnt   <= '0;
            r_sig   <= '0;
            r_busy  <= 1'b1;
            r_state <= StDrive;
          end
        end
        StDrive: begin
          // Abort takes priority over a capture on the same edge, so sig stays frozen.
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else if (w_settled) begin
            r_data  <= i_f_in;
            r_index <= r_row;
            r_sig   <= {r_sig[8:0], r_sig[9]} ^ i_f_in;
            r_valid <= 1'b1;
            r_state <= StPresent;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StPresent: begin
          if (w_xfer || i_abort) begin
            r_valid <= 1'b0;
          end
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else if (w_xfer) begin
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_row   <= r_row + 4'd1;
              r_cnt   <= '0;
              r_state <= StDrive;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign {o_w, o_x, o_y, o_z} = r_row;
  assign o_row_valid          = r_valid;
  assign o_row_index          = r_index;
  assign o_row_data           = r_data;
  assign o_busy               = r_busy;
  assign o_done               = r_done;
  assign o_sig                = r_sig;

endmodule

// File: tb/tb_breadboard_sweeper.sv
// Directed bench: stub breadboard model, full sweeps, signature, backpressure, abort, reset,
// start corner cases and a SETTLE=1 instance.
module tb_breadboard_sweeper;

  logic       clk = 1'b0;
  logic       rst, start, abort, ready;
  logic [9:0] f_in;
  logic       w, x, y, z, valid, busy, done;
  logic [3:0] idx;
  logic [9:0] data, sig;

  logic       start1;
  logic [9:0] f1_in;
  logic       w1, x1, y1, z1, valid1, busy1, done1;
  logic [3:0] idx1;
  logic [9:0] data1, sig1;

  int n_checks = 0;
  int n_errors = 0;

  int         mode;
  logic [15:0] stall_mask;
  int         abort_drive_row, abort_xfer_row, rst_row, start_pulse_k;
  bit         start_with_abort;
  int         xfers, n_done, done_k, first_valid;
  logic [9:0] sig_at_done;

  always #5 clk = ~clk;

  function automatic logic [9:0] exp_data(input int m, input logic [3:0] r);
    if (m == 0) return {r, ~r, 2'b01};
    else if (m == 1) return 10'h001;
    else return 10'h3FF;
  endfunction

  function automatic logic [9:0] exp_sig(input int m);
    logic [9:0] s = '0;
    for (int r = 0; r < 16; r++) s = {s[8:0], s[9]} ^ exp_data(m, 4'(r));
    return s;
  endfunction

  always_comb f_in  = exp_data(mode, {w, x, y, z});
  always_comb f1_in = exp_data(0, {w1, x1, y1, z1});

  breadboard_sweeper #(.SETTLE(6)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_f_in(f_in),
    .i_row_ready(ready), .o_w(w), .o_x(x), .o_y(y), .o_z(z), .o_row_valid(valid),
    .o_row_index(idx), .o_row_data(data), .o_busy(busy), .o_done(done), .o_sig(sig)
  );

  breadboard_sweeper #(.SETTLE(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_abort(1'b0), .i_f_in(f1_in),
    .i_row_ready(1'b1), .o_w(w1), .o_x(x1), .o_y(y1), .o_z(z1), .o_row_valid(valid1),
    .o_row_index(idx1), .o_row_data(data1), .o_busy(busy1), .o_done(done1), .o_sig(sig1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset();
    check("rst_valid", valid, 0);
    check("rst_index", idx, 0);
    check("rst_data", data, 0);
    check("rst_wxyz", {w, x, y, z}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sig", sig, 0);
  endtask

  task automatic set_defaults(input int m);
    mode = m; stall_mask = '0; abort_drive_row = -1; abort_xfer_row = -1;
    rst_row = -1; start_pulse_k = -1; start_with_abort = 0;
  endtask

  task automatic after_abort();
    logic [9:0] frozen;
    int dcount = 0;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    frozen = sig;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || valid) dcount++;
    end
    check("abort_quiet", dcount, 0);
    check("abort_sig_frozen", sig, frozen);
  endtask

  task automatic run_sweep();
    int  k = 1;
    int  stall_cnt = 0;
    int  exp_row = 0;
    bit  stop = 0;
    xfers = 0; n_done = 0; done_k = -1; first_valid = -1;
    @(negedge clk);
    start = 1'b1; abort = start_with_abort; ready = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("busy_n1", busy, 1);
    check("wxyz_n1", {w, x, y, z}, 0);
    while (!stop && k < 3000) begin
      start = (k == start_pulse_k);
      if (done) begin
        n_done++; done_k = k; sig_at_done = sig;
      end else if (n_done > 0) begin
        check("post_done_busy", busy, 0);
        stop = 1;
      end else if (valid) begin
        if (first_valid < 0) first_valid = k;
        check("row_index", idx, exp_row);
        check("row_data", data, exp_data(mode, 4'(exp_row)));
        check("row_wxyz", {w, x, y, z}, exp_row);
        if (exp_row == rst_row) begin
          rst = 1'b1; ready = 1'b0;
          @(negedge clk);
          rst = 1'b0; ready = 1'b1;
          chk_reset();
          stop = 1;
        end else if (stall_mask[exp_row] && stall_cnt < 5) begin
          ready = 1'b0; stall_cnt++;
        end else begin
          ready = 1'b1; stall_cnt = 0; xfers++;
          if (exp_row == abort_xfer_row) begin
            abort = 1'b1; after_abort(); stop = 1;
          end
          exp_row++;
        end
      end else if (busy && exp_row == abort_drive_row) begin
        abort = 1'b1; after_abort(); stop = 1;
      end
      if (!stop) begin
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    if (!stop) check("sweep_timeout", k, 0);
  endtask

  task automatic run_settle1();
    int k = 1;
    int d_k = -1;
    int fv = -1;
    int nv = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    while (d_k < 0 && k < 200) begin
      if (valid1) begin
        if (fv < 0) fv = k;
        check("s1_index", idx1, nv);
        nv++;
      end
      if (done1) d_k = k;
      @(negedge clk);
      k++;
    end
    check("s1_first_valid", fv, 2);
    check("s1_rows", nv, 16);
    check("s1_done_cycle", d_k, 33);
    check("s1_sig", sig1, exp_sig(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1; start1 = 1'b0;
    set_defaults(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset();

    set_defaults(0); run_sweep();
    check("full_xfers", xfers, 16);
    check("full_done_cycle", done_k, 113);
    check("full_done_count", n_done, 1);
    check("full_first_valid", first_valid, 7);
    check("full_sig", sig_at_done, exp_sig(0));

    set_defaults(1); run_sweep();
    check("sig_001", sig_at_done, 10'h3C0);
    set_defaults(2); run_sweep();
    check("sig_3ff", sig_at_done, 10'h000);

    set_defaults(0); stall_mask = 16'h8101; run_sweep();
    check("bp_xfers", xfers, 16);
    check("bp_done_cycle", done_k, 128);
    check("bp_done_count", n_done, 1);

    set_defaults(0); abort_drive_row = 4; run_sweep();
    check("abd_xfers", xfers, 4);
    check("abd_done", n_done, 0);

    set_defaults(0); abort_xfer_row = 9; run_sweep();
    check("abx_xfers", xfers, 10);
    check("abx_done", n_done, 0);

    set_defaults(0); start_pulse_k = 20; run_sweep();
    check("busy_start_done_cycle", done_k, 113);
    check("busy_start_xfers", xfers, 16);

    set_defaults(0); start_with_abort = 1; run_sweep();
    check("start_abort_done_cycle", done_k, 113);

    set_defaults(0); rst_row = 7; run_sweep();
    check("rst_mid_done", n_done, 0);
    set_defaults(0); run_sweep();
    check("post_rst_xfers", xfers, 16);
    check("post_rst_done_cycle", done_k, 113);

    run_settle1();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/breadboard_sweeper.md
# breadboard_sweeper

Sequencer that drives the 4-input breadboard logic through all 16 input combinations (w,x,y,z = row 0..15, w is the MSB). For each row it holds the inputs for a programmable settle interval, then captures the 10 function outputs. It presents each captured row on a valid/ready stream and accumulates a rotate-XOR signature over the sweep. It replaces the delay-driven sweep loop in the bench with a synthesizable controller sitting between the breadboard and a result sink (display/UART/checker).

## Interface

- SETTLE, 6, cycles the inputs are held before capture; legal range 1..255
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE
- abort  in  1  terminate the sweep; sampled in DRIVE and PRESENT
- w, x, y, z  out  1 each  breadboard inputs; {w,x,y,z} = current row
- f_in  in  10  breadboard outputs; bit k = f_k
- row_valid  out  1  captured row available
- row_ready  in  1  sink accepts the row
- row_index  out  4  row number of row_data
- row_data  out  10  captured f_in
- busy  out  1  high in DRIVE or PRESENT
- done  out  1  one-cycle pulse when row 15 has transferred
- sig  out  10  running signature; final value is valid from the done cycle until the next start

## Operation

- States: IDLE, DRIVE, PRESENT, DONE.
- **IDLE**
  - start=1: row←0, settle counter←0, sig←0, go to DRIVE.
  - Otherwise stay in IDLE.
- **DRIVE**
  - {w,x,y,z} = row; the counter increments each cycle.
  - In the cycle where the counter = SETTLE-1: row_data←f_in, row_index←row, sig←{sig[8:0],sig[9]} ^ f_in, go to PRESENT.
- **PRESENT**
  - row_valid=1; row_data, row_index and {w,x,y,z} are held stable.
  - A transfer occurs on an edge where row_valid & row_ready.
  - On transfer with row=15: go to DONE.
  - On transfer with row<15: row←row+1, counter←0, go to DRIVE.
  - With no transfer: stay in PRESENT indefinitely.
- **DONE**
  - done=1 for exactly one cycle, then go to IDLE. {w,x,y,z} stay at 1111.
- **abort** (DRIVE or PRESENT): go to IDLE on the next edge. row_valid drops, no transfer is counted, done is not pulsed, sig is frozen (partial value).
  - abort and a transfer on the same edge: the transfer completes, the state still goes to IDLE, done is not pulsed.
- start is ignored outside IDLE. start and abort together in IDLE: start wins.
- Row counter: 4 bits; it never wraps within a sweep (the exit at 15 precedes any increment).
- Settle counter: 8 bits.
- **Reset values:** state IDLE; w,x,y,z=0; row_valid=0; row_index=0; row_data=0; busy=0; done=0; sig=0.
- Reset mid-sweep discards all progress, and the reset values appear on the cycle after the reset edge.

## Timing

- All outputs are registered; no combinational path from any input to any output.
- Start accepted at edge N:
  - busy=1 and {w,x,y,z}=0000 from cycle N+1.
  - Capture at the end of cycle N+SETTLE.
  - row_valid=1 from cycle N+SETTLE+1.
- With row_ready held high, each row takes SETTLE+1 cycles. done is high in cycle N+16·(SETTLE+1)+1; for SETTLE=6 that is N+113.
- A row_ready stall of k cycles extends the sweep by exactly k cycles.
- row_valid is never high in DRIVE, IDLE or DONE, so back-to-back rows always have at least SETTLE cycles of valid low between them.
- f_in is sampled only on the capture edge. Glitches during settling are invisible.

## Test plan

- **Reset:** assert rst mid-PRESENT at row 7 -> next cycle all outputs are at their reset values; a subsequent start sweeps from row 0.
- **Full sweep, stub model:** f_in = {row, ~row, 2'b01}, row_ready=1, SETTLE=6, start at edge N -> 16 transfers with row_index 0..15, row_data matching the model per row, done only in cycle N+113, busy low afterwards.
- **Signature:** f_in held at 10'h001 -> sig=10'h3C0 at done. f_in held at 10'h3FF -> sig=10'h000.
- **Backpressure:** row_ready low for 5 cycles on rows 0, 8 and 15 -> row_data, row_index and w..z stable during the stalls; done delayed by exactly 15 cycles; no row lost or duplicated.
- **Abort:** abort in DRIVE at row 4 -> IDLE next cycle, no done, row_valid low. Abort coincident with the row-9 transfer -> 10 transfers counted, then IDLE, no done.
- **Start edge cases:**
  - start pulsed during busy -> ignored.
  - start and abort together in IDLE -> sweep begins.
  - SETTLE=1 -> rows every 2 cycles and done at N+33.
